// File: rtl/qdr_replay_ctrl.sv
// qdr_replay_ctrl: store/replay sequencer for the QDR datapath; optional read pacing under REPLAY_RATE_LIMIT_EN
module qdr_replay_ctrl #(
    parameter int MEM_ADDR_WIDTH     = 19,
    parameter int MAX_OUTSTANDING    = 16,
    parameter int REPLAY_COUNT_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sw_rst,
    input  logic                          cal_done,
    input  logic                          start_store,
    input  logic                          start_replay,
    input  logic                          compelete_replay,
    input  logic [REPLAY_COUNT_WIDTH-1:0] replay_count,
    input  logic                          in_fifo_empty,
    output logic                          in_fifo_rd_en,
    output logic                          app_wr_cmd,
    output logic [MEM_ADDR_WIDTH-1:0]     app_wr_addr,
    output logic                          app_rd_cmd,
    output logic [MEM_ADDR_WIDTH-1:0]     app_rd_addr,
    input  logic                          app_rd_valid,
    input  logic                          out_fifo_nearly_full,
`ifdef REPLAY_RATE_LIMIT_EN
    input  logic [7:0]                    rate_gap,
`endif
    output logic [MEM_ADDR_WIDTH-1:0]     mem_addr_high,
    output logic                          mem_full,
    output logic [2:0]                    state,
    output logic [REPLAY_COUNT_WIDTH-1:0] pass_cnt,
    output logic                          replay_done
);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [MEM_ADDR_WIDTH-1:0] ONE = 1;
    localparam logic [MEM_ADDR_WIDTH-1:0] LAST = {MEM_ADDR_WIDTH{1'b1}};
    localparam logic [REPLAY_COUNT_WIDTH-1:0] PONE = 1;
    localparam logic [OW-1:0] MAX_O = OW'(MAX_OUTSTANDING);
    typedef enum logic [2:0] {IDLE = 3'd0, STORE = 3'd1, FLUSH = 3'd2, REPLAY = 3'd3, DRAIN = 3'd4, DONE = 3'd5} state_t;
    state_t state_q, state_d;
    logic store_q, replay_q, comp_q;
    logic [MEM_ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [OW-1:0] outstanding;
    logic rst_all, store_edge, replay_edge, comp_edge, issue, wrap, last_pass, gap_ok;
    assign rst_all     = rst | sw_rst;
    assign store_edge  = start_store & ~store_q;
    assign replay_edge = start_replay & ~replay_q;
    assign comp_edge   = compelete_replay & ~comp_q;
    assign wrap        = rd_ptr == mem_addr_high - ONE;
    assign last_pass   = (replay_count != '0) && (pass_cnt + PONE == replay_count);
    assign state       = state_q;
    assign replay_done = state_q == DONE;
`ifdef REPLAY_RATE_LIMIT_EN
    logic [7:0] gap_cnt;
    assign gap_ok = gap_cnt == 8'd0;
    // enforce rate_gap idle cycles after each read command
    always_ff @(posedge clk) begin
        if (rst_all) gap_cnt <= '0;
        else gap_cnt <= issue ? rate_gap : (gap_ok ? gap_cnt : gap_cnt - 8'd1);
    end
`else
    assign gap_ok = 1'b1;
`endif
    // next state, FIFO pop and read-issue decision
    always_comb begin
        state_d       = state_q;
        in_fifo_rd_en = 1'b0;
        issue         = 1'b0;
        case (state_q)
            IDLE:   state_d = (store_edge & cal_done) ? STORE : IDLE;
            STORE: begin
                in_fifo_rd_en = ~in_fifo_empty & ~mem_full & ~replay_edge;
                state_d       = replay_edge ? FLUSH : STORE;
            end
            FLUSH:  state_d = (wr_ptr == '0) ? DONE : REPLAY;
            REPLAY: begin
                issue   = ~comp_edge & (outstanding < MAX_O) & ~out_fifo_nearly_full & gap_ok;
                state_d = (comp_edge | (issue & wrap & last_pass)) ? DRAIN : REPLAY;
            end
            DRAIN:  state_d = (outstanding == '0) ? DONE : DRAIN;
            DONE:   state_d = store_edge ? STORE : ((replay_edge & (mem_addr_high != '0)) ? REPLAY : DONE);
            default: state_d = IDLE;
        endcase
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst_all) state_q <= IDLE;
        else state_q <= state_d;
    end
    // edge detectors, pointers, credits and registered QDR commands
    always_ff @(posedge clk) begin
        if (rst_all) begin
            store_q       <= start_store;
            replay_q      <= start_replay;
            comp_q        <= compelete_replay;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            outstanding   <= '0;
            pass_cnt      <= '0;
            mem_addr_high <= '0;
            mem_full      <= 1'b0;
            app_wr_cmd    <= 1'b0;
            app_wr_addr   <= '0;
            app_rd_cmd    <= 1'b0;
            app_rd_addr   <= '0;
        end else begin
            store_q    <= start_store;
            replay_q   <= start_replay;
            comp_q     <= compelete_replay;
            app_wr_cmd <= in_fifo_rd_en;
            app_rd_cmd <= issue;
            if (state_d == STORE && state_q != STORE) begin
                wr_ptr   <= '0;
                mem_full <= 1'b0;
            end
            if (in_fifo_rd_en) begin
                app_wr_addr <= wr_ptr;
                wr_ptr      <= wr_ptr + ONE;
                if (wr_ptr + ONE == LAST) mem_full <= 1'b1;
            end
            if (state_q == FLUSH) mem_addr_high <= wr_ptr;
            if (state_d == REPLAY && state_q != REPLAY) begin
                rd_ptr   <= '0;
                pass_cnt <= '0;
            end
            if (issue) begin
                app_rd_addr <= rd_ptr;
                rd_ptr      <= wrap ? '0 : rd_ptr + ONE;
                if (wrap) pass_cnt <= pass_cnt + PONE;
            end
            if (issue & ~app_rd_valid) outstanding <= outstanding + OW'(1);
            else if (~issue & app_rd_valid & (outstanding != '0)) outstanding <= outstanding - OW'(1);
        end
    end
endmodule
